term_controller: RTL and testbench
==================================

TERM_CONTROLLER -- requirements
Module: term_controller

Interface
REQ-001 Parameter COLS, default 80: text columns per row.
REQ-002 Parameter ROWS, default 25: text rows; CELLS = COLS*ROWS = 2000, which SHALL fit in 11 bits.
REQ-003 Port clk100  in  1: sole clock; all logic on posedge.
REQ-004 Port rst_n  in  1: reset is asynchronous and active-low.
REQ-005 Port char_valid  in  1: producer offers a byte.
REQ-006 Port char_data  in  8: offered byte.
REQ-007 Port char_ready  out  1: controller accepts the byte; transfer occurs on a posedge where char_valid && char_ready.
REQ-008 Port cursor  out  11: linear cell index of the cursor, driven to the display block.
REQ-009 Port wr_start  out  1: single-cycle request pulse to the display write engine.
REQ-010 Port wr_begin  out  11: first cell of the operation.
REQ-011 Port wr_end  out  11: exclusive end cell.
REQ-012 Port wr_data  out  8: fill byte.
REQ-013 Port wr_offset  out  8: source offset; 0 = fill, nonzero = copy from cell+offset.
REQ-014 Port wr_complete  in  1: one-cycle done pulse from the display write engine.

Function
REQ-015 States SHALL be CLS, CLS_WAIT, IDLE, PUT, PUT_WAIT, SCR_COPY, SCR_COPY_WAIT, SCR_CLR, SCR_CLR_WAIT.
REQ-016 char_ready SHALL be 1 only in IDLE; a byte is accepted in IDLE only.
REQ-017 Issue states (CLS, PUT, SCR_COPY, SCR_CLR) SHALL assert wr_start for exactly one cycle, load the wr_* outputs on that same edge, then move to the matching *_WAIT state.
REQ-018 The wr_begin, wr_end, wr_data and wr_offset outputs SHALL be held stable from the wr_start cycle until wr_complete is sampled.
REQ-019 *_WAIT states SHALL remain until wr_complete = 1; no timeout. wr_complete in any other state SHALL be ignored.
REQ-020 Decode on accept, with col = cursor mod COLS and row = cursor / COLS:
 - 0x0D (CR): cursor <= row*COLS on the accept edge; stay in IDLE.
 - 0x0A (LF): if row < ROWS-1, cursor <= cursor+COLS on the accept edge and stay in IDLE; else go to SCR_COPY with cursor unchanged.
 - 0x08 (BS): if col > 0, cursor <= cursor-1, else unchanged; no cell write.
 - 0x0C (FF): go to CLS.
 - other bytes < 0x20: accepted and discarded; no state change.
 - bytes >= 0x20: go to PUT, latching the byte.
REQ-021 CLS SHALL issue wr_begin=0, wr_end=CELLS, wr_data=0x20, wr_offset=0; on completion cursor <= 0 and the FSM goes to IDLE.
REQ-022 PUT SHALL issue wr_begin=cursor, wr_end=cursor+1, wr_data=latched byte, wr_offset=0.
REQ-023 On PUT completion: if col < COLS-1, cursor <= cursor+1 and go to IDLE; else if row < ROWS-1, cursor <= (row+1)*COLS and go to IDLE; else go to SCR_COPY with cursor <= (ROWS-1)*COLS.
REQ-024 SCR_COPY SHALL issue wr_begin=0, wr_end=(ROWS-1)*COLS=1920, wr_offset=COLS=80; wr_data is don't-care.
REQ-025 SCR_CLR, entered after SCR_COPY completion, SHALL issue wr_begin=1920, wr_end=CELLS, wr_data=0x20, wr_offset=0; on completion go to IDLE with cursor unchanged.
REQ-026 Cursor arithmetic SHALL be 11-bit unsigned and SHALL never leave 0..CELLS-1.
REQ-027 Minimum latency from accept edge to wr_start high SHALL be 1 cycle.
REQ-028 A byte held on char_valid while char_ready=0 SHALL be neither consumed nor corrupted.

Reset
REQ-029 On rst_n low: state=CLS, cursor=0, char_ready=0, wr_start=0, wr_begin=0, wr_end=0, wr_data=0, wr_offset=0.
REQ-030 After deassertion, the first posedge SHALL issue the CLS operation, so every reset clears the screen.
REQ-031 rst_n SHALL be the same reset that clears the display write engine; an operation in flight at reset is abandoned and never reported.

Verification
REQ-032 Release reset -> wr_start with begin 0 / end 2000 / data 0x20 / offset 0; after wr_complete, char_ready=1 and cursor=0.
REQ-033 Cursor 0, send 0x41 -> wr_start begin 0 / end 1 / data 0x41 / offset 0; after wr_complete, cursor=1.
REQ-034 Cursor 85, send 0x0D -> cursor 80 with no wr_start; then send 0x0A -> cursor 160; then send 0x08 three times from cursor 162 -> cursor 160, then stays 160.
REQ-035 Cursor 1925, send 0x0A -> copy op begin 0 / end 1920 / offset 80, then clear op begin 1920 / end 2000 / data 0x20; cursor stays 1925 and char_ready=0 throughout.
REQ-036 Cursor 1999, send 0x5A -> write at 1999, then scroll copy and clear; final cursor 1920.
REQ-037 wr_complete pulsed in IDLE -> no state or cursor change; rst_n asserted during PUT_WAIT -> all outputs at reset values immediately, followed by a fresh CLS.

Source files
------------

// File: rtl/term_controller_if.sv
// Byte-producer and display-write-engine signals of the text terminal controller.
// The controller side takes the master modport; the producer/engine side takes slave.
interface term_controller_if;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic [10:0] cursor;
    logic        wr_start;
    logic [10:0] wr_begin;
    logic [10:0] wr_end;
    logic [7:0]  wr_data;
    logic [7:0]  wr_offset;
    logic        wr_complete;

    modport master (
        input  char_valid, char_data, wr_complete,
        output char_ready, cursor, wr_start, wr_begin, wr_end, wr_data, wr_offset
    );

    modport slave (
        output char_valid, char_data, wr_complete,
        input  char_ready, cursor, wr_start, wr_begin, wr_end, wr_data, wr_offset
    );
endinterface

// File: rtl/term_controller.sv
// Text terminal controller: decodes incoming bytes into cursor moves and fill/copy
// requests for the display write engine (clear screen, put character, scroll).
module term_controller #(
    parameter int COLS = 80,
    parameter int ROWS = 25
) (
    input  logic clk100,
    input  logic rst_n,
    term_controller_if.master bus
);
    localparam int CELLS = COLS * ROWS;
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);

    localparam logic [10:0]   CELLS_C   = 11'(CELLS);
    localparam logic [10:0]   COLS_C    = 11'(COLS);
    localparam logic [10:0]   LAST_BASE = 11'((ROWS - 1) * COLS);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_ZERO  = CW'(0);
    localparam logic [CW-1:0] COL_ONE   = CW'(1);
    localparam logic [RW-1:0] ROW_ZERO  = RW'(0);
    localparam logic [RW-1:0] ROW_ONE   = RW'(1);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam logic [3:0] S_CLS           = 4'd0;
    localparam logic [3:0] S_CLS_WAIT      = 4'd1;
    localparam logic [3:0] S_IDLE          = 4'd2;
    localparam logic [3:0] S_PUT           = 4'd3;
    localparam logic [3:0] S_PUT_WAIT      = 4'd4;
    localparam logic [3:0] S_SCR_COPY      = 4'd5;
    localparam logic [3:0] S_SCR_COPY_WAIT = 4'd6;
    localparam logic [3:0] S_SCR_CLR       = 4'd7;
    localparam logic [3:0] S_SCR_CLR_WAIT  = 4'd8;

    logic [3:0]    state_q,     state_d;
    logic [10:0]   cursor_q,    cursor_d;
    logic [CW-1:0] col_q,       col_d;
    logic [RW-1:0] row_q,       row_d;
    logic [7:0]    byte_q,      byte_d;
    logic          ready_q,     ready_d;
    logic          wr_start_q,  wr_start_d;
    logic [10:0]   wr_begin_q,  wr_begin_d;
    logic [10:0]   wr_end_q,    wr_end_d;
    logic [7:0]    wr_data_q,   wr_data_d;
    logic [7:0]    wr_offset_q, wr_offset_d;
    logic          accept_s;

    // Row and column are tracked alongside the linear cursor so no divider is needed.
    assign accept_s = bus.char_valid && ready_q;

    // Next-state, cursor and write-request decode.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        col_d       = col_q;
        row_d       = row_q;
        byte_d      = byte_q;
        wr_start_d  = 1'b0;
        wr_begin_d  = wr_begin_q;
        wr_end_d    = wr_end_q;
        wr_data_d   = wr_data_q;
        wr_offset_d = wr_offset_q;
        case (state_q)
            S_CLS: begin
                wr_start_d  = 1'b1;
                wr_begin_d  = 11'd0;
                wr_end_d    = CELLS_C;
                wr_data_d   = CH_SPACE;
                wr_offset_d = 8'd0;
                state_d     = S_CLS_WAIT;
            end
            S_CLS_WAIT: begin
                if (bus.wr_complete) begin
                    cursor_d = 11'd0;
                    col_d    = COL_ZERO;
                    row_d    = ROW_ZERO;
                    state_d  = S_IDLE;
                end else begin
                    state_d  = S_CLS_WAIT;
                end
            end
            S_IDLE: begin
                if (accept_s) begin
                    case (bus.char_data)
                        CH_CR: begin
                            cursor_d = cursor_q - 11'(col_q);
                            col_d    = COL_ZERO;
                        end
                        CH_LF: begin
                            if (row_q < ROW_LAST) begin
                                cursor_d = cursor_q + COLS_C;
                                row_d    = row_q + ROW_ONE;
                            end else begin
                                state_d  = S_SCR_COPY;
                            end
                        end
                        CH_BS: begin
                            if (col_q != COL_ZERO) begin
                                cursor_d = cursor_q - 11'd1;
                                col_d    = col_q - COL_ONE;
                            end else begin
                                cursor_d = cursor_q;
                            end
                        end
                        CH_FF: state_d = S_CLS;
                        default: begin
                            // Remaining control codes are swallowed without effect.
                            if (bus.char_data >= CH_SPACE) begin
                                byte_d  = bus.char_data;
                                state_d = S_PUT;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PUT: begin
                wr_start_d  = 1'b1;
                wr_begin_d  = cursor_q;
                wr_end_d    = cursor_q + 11'd1;
                wr_data_d   = byte_q;
                wr_offset_d = 8'd0;
                state_d     = S_PUT_WAIT;
            end
            S_PUT_WAIT: begin
                if (!bus.wr_complete) begin
                    state_d = S_PUT_WAIT;
                end else if (col_q < COL_LAST) begin
                    cursor_d = cursor_q + 11'd1;
                    col_d    = col_q + COL_ONE;
                    state_d  = S_IDLE;
                end else if (row_q < ROW_LAST) begin
                    cursor_d = cursor_q + 11'd1;
                    col_d    = COL_ZERO;
                    row_d    = row_q + ROW_ONE;
                    state_d  = S_IDLE;
                end else begin
                    cursor_d = LAST_BASE;
                    col_d    = COL_ZERO;
                    row_d    = ROW_LAST;
                    state_d  = S_SCR_COPY;
                end
            end
            S_SCR_COPY: begin
                wr_start_d  = 1'b1;
                wr_begin_d  = 11'd0;
                wr_end_d    = LAST_BASE;
                wr_data_d   = CH_SPACE;
                wr_offset_d = 8'(COLS);
                state_d     = S_SCR_COPY_WAIT;
            end
            S_SCR_COPY_WAIT: begin
                if (bus.wr_complete) begin
                    state_d = S_SCR_CLR;
                end else begin
                    state_d = S_SCR_COPY_WAIT;
                end
            end
            S_SCR_CLR: begin
                wr_start_d  = 1'b1;
                wr_begin_d  = LAST_BASE;
                wr_end_d    = CELLS_C;
                wr_data_d   = CH_SPACE;
                wr_offset_d = 8'd0;
                state_d     = S_SCR_CLR_WAIT;
            end
            S_SCR_CLR_WAIT: begin
                if (bus.wr_complete) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SCR_CLR_WAIT;
                end
            end
            default: begin
                cursor_d = 11'd0;
                col_d    = COL_ZERO;
                row_d    = ROW_ZERO;
                state_d  = S_CLS;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset lands in CLS so every reset clears the screen.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CLS;
            cursor_q    <= 11'd0;
            col_q       <= COL_ZERO;
            row_q       <= ROW_ZERO;
            byte_q      <= 8'd0;
            ready_q     <= 1'b0;
            wr_start_q  <= 1'b0;
            wr_begin_q  <= 11'd0;
            wr_end_q    <= 11'd0;
            wr_data_q   <= 8'd0;
            wr_offset_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            col_q       <= col_d;
            row_q       <= row_d;
            byte_q      <= byte_d;
            ready_q     <= ready_d;
            wr_start_q  <= wr_start_d;
            wr_begin_q  <= wr_begin_d;
            wr_end_q    <= wr_end_d;
            wr_data_q   <= wr_data_d;
            wr_offset_q <= wr_offset_d;
        end
    end

    assign bus.char_ready = ready_q;
    assign bus.cursor     = cursor_q;
    assign bus.wr_start   = wr_start_q;
    assign bus.wr_begin   = wr_begin_q;
    assign bus.wr_end     = wr_end_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_offset  = wr_offset_q;
endmodule

// File: tb/tb_term_controller.sv
// Bench for term_controller: directed and random byte streams checked against a
// cursor/operation model computed from row/column arithmetic.
module tb_term_controller;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    term_controller_if bus ();

    term_controller #(.COLS(80), .ROWS(25)) dut (
        .clk100 (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_cur;
    int q_beg[$];
    int q_end[$];
    int q_dat[$];
    int q_off[$];
    logic [7:0] seq_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_op(input int b, input int e, input int d, input int o);
        q_beg.push_back(b);
        q_end.push_back(e);
        q_dat.push_back(d);
        q_off.push_back(o);
    endtask

    task automatic clear_ops();
        q_beg.delete();
        q_end.delete();
        q_dat.delete();
        q_off.delete();
    endtask

    // Reference: expected write operations and final cursor for one accepted byte.
    task automatic model_byte(input logic [7:0] b);
        int row;
        int col;
        row = m_cur / 80;
        col = m_cur % 80;
        if (b == 8'h0D) begin
            m_cur = row * 80;
        end else if (b == 8'h0A) begin
            if (row < 24) m_cur = m_cur + 80;
            else begin
                push_op(0, 1920, -1, 80);
                push_op(1920, 2000, 32, 0);
            end
        end else if (b == 8'h08) begin
            if (col > 0) m_cur = m_cur - 1;
        end else if (b == 8'h0C) begin
            push_op(0, 2000, 32, 0);
            m_cur = 0;
        end else if (b >= 8'h20) begin
            push_op(m_cur, m_cur + 1, int'(b), 0);
            if (col < 79) m_cur = m_cur + 1;
            else if (row < 24) m_cur = (row + 1) * 80;
            else begin
                push_op(0, 1920, -1, 80);
                push_op(1920, 2000, 32, 0);
                m_cur = 1920;
            end
        end
    endtask

    // Acts as the write engine for every queued op, then checks the idle state.
    task automatic run_ops();
        int waited;
        int dly;
        logic [37:0] held;
        while (q_beg.size() > 0) begin
            waited = 0;
            while (bus.wr_start !== 1'b1 && waited < 30) begin
                @(negedge clk);
                waited++;
            end
            if (bus.wr_start !== 1'b1) begin
                chk("wr_start_timeout", 64'(0), 64'(1));
                clear_ops();
                return;
            end
            chk("issue_latency", 64'(waited), 64'(1));
            chk("wr_begin", 64'(bus.wr_begin), 64'(q_beg[0]));
            chk("wr_end", 64'(bus.wr_end), 64'(q_end[0]));
            chk("wr_offset", 64'(bus.wr_offset), 64'(q_off[0]));
            if (q_dat[0] >= 0) chk("wr_data", 64'(bus.wr_data), 64'(q_dat[0]));
            chk("ready_busy", 64'(bus.char_ready), 64'(0));
            held = {bus.wr_begin, bus.wr_end, bus.wr_data, bus.wr_offset};
            dly = $urandom_range(1, 4);
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                if (i == 0) chk("wr_start_pulse", 64'(bus.wr_start), 64'(0));
            end
            chk("wr_hold", 64'({bus.wr_begin, bus.wr_end, bus.wr_data, bus.wr_offset}), 64'(held));
            bus.wr_complete = 1'b1;
            @(negedge clk);
            bus.wr_complete = 1'b0;
            void'(q_beg.pop_front());
            void'(q_end.pop_front());
            void'(q_dat.pop_front());
            void'(q_off.pop_front());
        end
        chk("cursor", 64'(bus.cursor), 64'(m_cur));
        chk("ready_idle", 64'(bus.char_ready), 64'(1));
    endtask

    // Offers b until accepted, then keeps char_valid up with the next byte while busy.
    task automatic do_byte(input logic [7:0] b, input logic [7:0] nxt, input bit keep);
        int w;
        w = 0;
        bus.char_valid = 1'b1;
        bus.char_data  = b;
        while (bus.char_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (bus.char_ready !== 1'b1) begin
            chk("ready_timeout", 64'(0), 64'(1));
            bus.char_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (keep) bus.char_data = nxt;
        else bus.char_valid = 1'b0;
        model_byte(b);
        run_ops();
    endtask

    task automatic send_seq();
        for (int i = 0; i < seq_q.size(); i++) begin
            if (i + 1 < seq_q.size()) do_byte(seq_q[i], seq_q[i+1], 1'b1);
            else do_byte(seq_q[i], 8'h00, 1'b0);
        end
        seq_q.delete();
    endtask

    task automatic chk_reset();
        chk("rst_cursor", 64'(bus.cursor), 64'(0));
        chk("rst_ready", 64'(bus.char_ready), 64'(0));
        chk("rst_wr_start", 64'(bus.wr_start), 64'(0));
        chk("rst_wr_begin", 64'(bus.wr_begin), 64'(0));
        chk("rst_wr_end", 64'(bus.wr_end), 64'(0));
        chk("rst_wr_data", 64'(bus.wr_data), 64'(0));
        chk("rst_wr_offset", 64'(bus.wr_offset), 64'(0));
    endtask

    initial begin
        int r;
        int v;
        int w;
        bus.char_valid  = 1'b0;
        bus.char_data   = 8'h00;
        bus.wr_complete = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        m_cur = 0;
        push_op(0, 2000, 32, 0);
        run_ops();

        seq_q.push_back(8'h41);
        send_seq();
        chk("put_first_cursor", 64'(bus.cursor), 64'(1));

        repeat (84) seq_q.push_back(8'h41);
        seq_q.push_back(8'h0D);
        seq_q.push_back(8'h0A);
        seq_q.push_back(8'h41);
        seq_q.push_back(8'h41);
        repeat (3) seq_q.push_back(8'h08);
        send_seq();
        chk("bs_floor_cursor", 64'(bus.cursor), 64'(160));

        seq_q.push_back(8'h0C);
        repeat (24) seq_q.push_back(8'h0A);
        repeat (5) seq_q.push_back(8'h42);
        seq_q.push_back(8'h0A);
        send_seq();
        chk("scroll_lf_cursor", 64'(bus.cursor), 64'(1925));

        seq_q.push_back(8'h0D);
        repeat (79) seq_q.push_back(8'h43);
        seq_q.push_back(8'h5A);
        send_seq();
        chk("wrap_scroll_cursor", 64'(bus.cursor), 64'(1920));

        bus.wr_complete = 1'b1;
        @(negedge clk);
        bus.wr_complete = 1'b0;
        @(negedge clk);
        chk("idle_cmpl_cursor", 64'(bus.cursor), 64'(m_cur));
        chk("idle_cmpl_ready", 64'(bus.char_ready), 64'(1));
        chk("idle_cmpl_start", 64'(bus.wr_start), 64'(0));

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50) v = $urandom_range(32, 255);
            else if (r < 60) v = 8'h0D;
            else if (r < 78) v = 8'h0A;
            else if (r < 88) v = 8'h08;
            else if (r < 90) v = 8'h0C;
            else begin
                v = $urandom_range(0, 31);
                if (v == 8 || v == 10 || v == 12 || v == 13) v = 27;
            end
            seq_q.push_back(8'(v));
        end
        send_seq();

        bus.char_valid = 1'b1;
        bus.char_data  = 8'h51;
        w = 0;
        while (bus.char_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        bus.char_valid = 1'b0;
        w = 0;
        while (bus.wr_start !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("put_before_reset", 64'(bus.wr_start), 64'(1));
        rst_n = 1'b0;
        #1;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;
        m_cur = 0;
        clear_ops();
        push_op(0, 2000, 32, 0);
        run_ops();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
